// File: rtl/pico_card_info_pkg.sv
// Shared definitions for the PicoBus card-info block: register word offsets,
// magic number, EVENT field layout and the legal parameter values.
package pico_card_info_pkg;

  localparam logic [15:0] PICO_MAGIC_NUM = 16'hC0DE;

  // Word index (byte offset / 4) of each register inside the 256-byte window
  typedef enum logic [5:0] {
    REG_STATUS    = 6'h00,
    REG_CAPS      = 6'h01,
    REG_VERSION   = 6'h02,
    REG_WIDTHS    = 6'h03,
    REG_MODEL     = 6'h04,
    REG_UPTIME_LO = 6'h05,
    REG_UPTIME_HI = 6'h06,
    REG_EVENT     = 6'h07,
    REG_SCRATCH0  = 6'h08
  } regWordT;

  localparam int EV_LOCK_LOST_BIT = 0;
  localparam int EV_CNT_LSB       = 8;
  localparam int EV_CNT_MSB       = 15;
  localparam int EV_CNT_CLR_BIT   = 31;

  localparam int MAX_SCRATCH = 8;

  function automatic bit isValidDataW(input int w);
    return (w == 32) || (w == 128);
  endfunction

  function automatic bit isValidLatency(input int l);
    return (l == 1) || (l == 2);
  endfunction

  function automatic bit isValidScratch(input int n);
    return (n >= 1) && (n <= MAX_SCRATCH);
  endfunction

endpackage

// File: rtl/pico_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable
// value loaded while PicoRst is high.
module pico_bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic PicoClk,
  input  logic PicoRst,
  input  logic pin,
  output logic synced
);

  logic meta;

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
    end else begin
      meta   <= pin;
      synced <= meta;
    end
  end

endmodule

// File: rtl/pico_card_info.sv
// Card identity and housekeeping registers on PicoBus: static ID words, a
// coherent 64-bit uptime counter, a DCM-lock event log and scratch registers.
module pico_card_info
  import pico_card_info_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          NUM_SCRATCH  = 4,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] MODEL_NUM    = 16'h0000,
  parameter logic [31:0] VERSION      = 32'h0,
  parameter logic [11:0] SIGNATURE    = 12'h000,
  parameter logic [31:0] CAPS         = 32'h0
) (
  input  logic              PicoClk,
  input  logic              PicoRst,
  input  logic [31:0]       PicoAddr,
  input  logic [DATA_W-1:0] PicoDataIn,
  output logic [DATA_W-1:0] PicoDataOut,
  input  logic              PicoRd,
  input  logic              PicoWr,
  input  logic [7:0]        UserPBWidth,
  input  logic              DcmLocked,
  input  logic              FlashStatus
);

  if (!isValidDataW(DATA_W)) begin : gBadDataW
    $error("pico_card_info: DATA_W must be 32 or 128");
  end
  if (!isValidLatency(READ_LATENCY)) begin : gBadLatency
    $error("pico_card_info: READ_LATENCY must be 1 or 2");
  end
  if (!isValidScratch(NUM_SCRATCH)) begin : gBadScratch
    $error("pico_card_info: NUM_SCRATCH must be 1..8");
  end

  localparam logic [5:0] SCR_END = 6'(int'(REG_SCRATCH0) + NUM_SCRATCH);

  logic        dcmS, flashS;
  logic        hit, rdHit, wrHit;
  logic [5:0]  word;
  logic [31:0] wrData;
  logic        isScratch;
  logic [2:0]  scrIdx;
  logic [63:0] count;
  logic [31:0] hiSnap;
  logic        dcmPrev, dcmFall, evWr;
  logic        lockLost;
  logic [7:0]  lostCnt;
  logic [31:0] eventWord;
  logic [31:0] scratch [NUM_SCRATCH];
  logic [31:0] scrRd;
  logic [31:0] rdWord;
  logic [31:0] dataQ1;
  logic [31:0] outWord;
  logic        unusedBits;

  pico_bit_sync #(.RESET_VAL(1'b0)) uDcmSync (
    .PicoClk (PicoClk),
    .PicoRst (PicoRst),
    .pin     (DcmLocked),
    .synced  (dcmS)
  );

  pico_bit_sync #(.RESET_VAL(1'b0)) uFlashSync (
    .PicoClk (PicoClk),
    .PicoRst (PicoRst),
    .pin     (FlashStatus),
    .synced  (flashS)
  );

  assign hit        = (PicoAddr[31:8] == BASE_ADDR[31:8]);
  assign word       = PicoAddr[7:2];
  assign rdHit      = PicoRd && hit;
  assign wrHit      = PicoWr && hit;
  assign wrData     = PicoDataIn[31:0];
  assign isScratch  = (word >= REG_SCRATCH0) && (word < SCR_END);
  assign scrIdx     = 3'(word - REG_SCRATCH0);
  assign unusedBits = ^{PicoDataIn, PicoAddr[1:0]};

  // Free-running uptime; hiSnap freezes the upper half when the low half is
  // read so a LO-then-HI pair is coherent across a carry.
  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      count  <= 64'd0;
      hiSnap <= 32'd0;
    end else begin
      count <= count + 64'd1;
      if (rdHit && (word == REG_UPTIME_LO))
        hiSnap <= count[63:32];
    end
  end

  assign dcmFall = dcmPrev && !dcmS;
  assign evWr    = wrHit && (word == REG_EVENT);

  // A lock fall landing in the same cycle as a clear wins over the clear.
  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      dcmPrev  <= 1'b0;
      lockLost <= 1'b0;
      lostCnt  <= 8'd0;
    end else begin
      dcmPrev <= dcmS;
      if (dcmFall)
        lockLost <= 1'b1;
      else if (evWr && wrData[EV_LOCK_LOST_BIT])
        lockLost <= 1'b0;
      if (evWr && wrData[EV_CNT_CLR_BIT])
        lostCnt <= dcmFall ? 8'd1 : 8'd0;
      else if (dcmFall && (lostCnt != 8'hFF))
        lostCnt <= lostCnt + 8'd1;
    end
  end

  always_comb begin
    eventWord                         = 32'd0;
    eventWord[EV_LOCK_LOST_BIT]       = lockLost;
    eventWord[EV_CNT_MSB:EV_CNT_LSB]  = lostCnt;
  end

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        scratch[i] <= 32'd0;
    end else if (wrHit && isScratch) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (scrIdx == 3'(i))
          scratch[i] <= wrData;
    end
  end

  always_comb begin
    scrRd = 32'd0;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (scrIdx == 3'(i))
        scrRd = scratch[i];
  end

  // Read mux sees state before this edge's write, giving read-before-write.
  always_comb begin
    rdWord = 32'd0;
    case (word)
      REG_STATUS:    rdWord = {SIGNATURE, 2'b00, dcmS, flashS, PICO_MAGIC_NUM};
      REG_CAPS:      rdWord = CAPS;
      REG_VERSION:   rdWord = VERSION;
      REG_WIDTHS:    rdWord = {16'h0000, UserPBWidth, 8'(DATA_W)};
      REG_MODEL:     rdWord = {16'h0000, MODEL_NUM};
      REG_UPTIME_LO: rdWord = count[31:0];
      REG_UPTIME_HI: rdWord = hiSnap;
      REG_EVENT:     rdWord = eventWord;
      default:       rdWord = isScratch ? scrRd : 32'd0;
    endcase
  end

  always_ff @(posedge PicoClk) begin
    if (PicoRst)
      dataQ1 <= 32'd0;
    else
      dataQ1 <= rdHit ? rdWord : 32'd0;
  end

  if (READ_LATENCY == 2) begin : gLat2
    logic [31:0] dataQ2;
    always_ff @(posedge PicoClk) begin
      if (PicoRst)
        dataQ2 <= 32'd0;
      else
        dataQ2 <= dataQ1;
    end
    assign outWord = dataQ2;
  end else begin : gLat1
    assign outWord = dataQ1;
  end

  assign PicoDataOut = DATA_W'(outWord);

endmodule

// File: tb/tb_pico_card_info.sv
// Self-checking bench for pico_card_info (128-bit bus, two-cycle read latency):
// table vectors, randomized scratch/identity traffic against a model, and
// hand sequences for uptime coherence, lock events and reset.
module tb_pico_card_info;

  localparam int          DW    = 128;
  localparam int          LAT   = 2;
  localparam int          NSCR  = 4;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] VER   = 32'h0102_0304;
  localparam logic [31:0] CAPSV = 32'h0000_00F1;
  localparam logic [15:0] MODEL = 16'h0E18;
  localparam logic [15:0] MAGIC = 16'hC0DE;
  localparam logic [11:0] SIG   = 12'hA5C;

  logic          PicoClk = 1'b0;
  logic          PicoRst;
  logic [31:0]   PicoAddr;
  logic [DW-1:0] PicoDataIn;
  logic [DW-1:0] PicoDataOut;
  logic          PicoRd, PicoWr;
  logic [7:0]    UserPBWidth;
  logic          DcmLocked, FlashStatus;

  pico_card_info #(
    .DATA_W(DW), .BASE_ADDR(BASE), .NUM_SCRATCH(NSCR), .READ_LATENCY(LAT),
    .MODEL_NUM(MODEL), .VERSION(VER), .SIGNATURE(SIG), .CAPS(CAPSV)
  ) dut (
    .PicoClk(PicoClk), .PicoRst(PicoRst), .PicoAddr(PicoAddr),
    .PicoDataIn(PicoDataIn), .PicoDataOut(PicoDataOut), .PicoRd(PicoRd),
    .PicoWr(PicoWr), .UserPBWidth(UserPBWidth), .DcmLocked(DcmLocked),
    .FlashStatus(FlashStatus)
  );

  always #5 PicoClk = ~PicoClk;

  typedef struct { logic [31:0] exp; bit lt8; string name; } pendT;
  typedef struct { bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; string name; } vecT;

  pendT        pend[$];
  vecT         tbl[$];
  logic [31:0] scr[8];
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] exp, input bit lt8);
    logic [DW-1:0] got;
    bit ok;
    got = PicoDataOut;
    if (lt8) ok = (got[DW-1:32] == '0) && (got[31:0] < 32'd8);
    else     ok = (got === DW'(exp));
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: PicoDataOut=%h required %s%h", name, got, lt8 ? "below " : "", DW'(exp));
  endtask

  // One bus cycle: check the result due now, then drive the next access.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp,
                               input bit lt8, input string name);
    pendT e, old;
    @(negedge PicoClk);
    if (pend.size() >= LAT) begin
      old = pend.pop_front();
      checkOutput(old.name, old.exp, old.lt8);
    end
    PicoRd = rd; PicoWr = wr; PicoAddr = addr; PicoDataIn = DW'(wdata);
    e.exp = rd ? exp : 32'd0; e.lt8 = rd && lt8; e.name = rd ? name : "idle";
    pend.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, "idle");
  endtask

  task automatic rdReg(input logic [7:0] off, input logic [31:0] exp, input string name);
    applyStimulus(1'b1, 1'b0, BASE + 32'(off), 32'd0, exp, 1'b0, name);
  endtask

  task automatic wrReg(input logic [7:0] off, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, BASE + 32'(off), d, 32'd0, 1'b0, "wr");
  endtask

  task automatic doReset();
    pendT e;
    @(negedge PicoClk);
    PicoRst = 1'b1; PicoRd = 1'b0; PicoWr = 1'b0;
    pend.delete();
    @(negedge PicoClk);
    checkOutput("rstFlush", 32'd0, 1'b0);
    repeat (2) @(negedge PicoClk);
    PicoRst = 1'b0;
    e.exp = 32'd0; e.lt8 = 1'b0; e.name = "idle";
    repeat (LAT) pend.push_back(e);
    idle(3);
  endtask

  task automatic fallDcm(input int n);
    repeat (n) begin
      DcmLocked = 1'b0; idle(3);
      DcmLocked = 1'b1; idle(3);
    end
  endtask

  function automatic logic [31:0] identVal(input int k);
    case (k)
      0:       return {SIG, 2'b00, 1'b1, 1'b1, MAGIC};
      1:       return CAPSV;
      2:       return VER;
      3:       return {16'h0000, 8'd64, 8'd128};
      default: return {16'h0000, MODEL};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int op, idx, k;
    logic [31:0] d, a, e;

    PicoRst = 1'b1; PicoRd = 1'b0; PicoWr = 1'b0; PicoAddr = '0; PicoDataIn = '0;
    UserPBWidth = 8'd64; DcmLocked = 1'b1; FlashStatus = 1'b1;
    doReset();

    tbl.push_back('{1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h0000_0E18, "model"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h0C, 32'h0, 32'h0000_4080, "widths"});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "idle"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h00, 32'h0, {SIG, 2'b00, 1'b1, 1'b1, MAGIC}, "status"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h04, 32'h0, CAPSV, "caps"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h08, 32'h0, VER, "version"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h1C, 32'h0, 32'h0, "eventRst"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h20, 32'h0, 32'h0, "scratchRst"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h18, 32'h0, 32'h0, "hiSnapRst"});
    tbl.push_back('{1'b1, 1'b0, 32'h0002_0010, 32'h0, 32'h0, "missRd"});
    tbl.push_back('{1'b1, 1'b1, BASE + 32'h2C, 32'hDEAD_BEEF, 32'h0, "scrRdWr"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h2C, 32'h0, 32'hDEAD_BEEF, "scrAfterWr"});
    tbl.push_back('{1'b0, 1'b1, BASE + 32'h30, 32'h1234_5678, 32'h0, "wr"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h30, 32'h0, 32'h0, "unmappedRd"});
    tbl.push_back('{1'b0, 1'b1, 32'h0002_0020, 32'hCAFE_F00D, 32'h0, "wr"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h20, 32'h0, 32'h0, "missWrIgnored"});
    tbl.push_back('{1'b1, 1'b0, BASE + 32'h44, 32'h0, 32'h0, "unmappedRd2"});
    foreach (tbl[i])
      applyStimulus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b0, tbl[i].name);

    // Randomized scratch and identity traffic against the model
    foreach (scr[i]) scr[i] = 32'd0;
    scr[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 5));
      idx = int'($urandom_range(0, 7));
      k   = int'($urandom_range(0, 4));
      d   = $urandom;
      a   = BASE + 32'(32 + idx * 4);
      e   = (idx < NSCR) ? scr[idx] : 32'd0;
      case (op)
        0: begin
          applyStimulus(1'b0, 1'b1, a, d, 32'd0, 1'b0, "rnd");
          if (idx < NSCR) scr[idx] = d;
        end
        1: applyStimulus(1'b1, 1'b0, a, 32'd0, e, 1'b0, "rndScrRd");
        2: begin
          applyStimulus(1'b1, 1'b1, a, d, e, 1'b0, "rndScrRdWr");
          if (idx < NSCR) scr[idx] = d;
        end
        3: applyStimulus(1'b1, 1'b0, BASE + 32'(k * 4), 32'd0, identVal(k), 1'b0, "rndIdent");
        4: begin
          applyStimulus(1'b0, 1'b1, 32'h0003_0000 + a[7:0], d, 32'd0, 1'b0, "rnd");
          applyStimulus(1'b1, 1'b0, 32'h0003_0000 + a[7:0], 32'd0, 32'd0, 1'b0, "rndMissRd");
        end
        default: idle(1);
      endcase
    end

    // Lock-loss event log
    fallDcm(3);
    idle(3);
    rdReg(8'h1C, 32'h0000_0301, "event3Falls");
    wrReg(8'h1C, 32'h0000_0001);
    rdReg(8'h1C, 32'h0000_0300, "eventClrLost");
    wrReg(8'h1C, 32'h8000_0000);
    rdReg(8'h1C, 32'h0000_0000, "eventClrCnt");
    fallDcm(300);
    idle(3);
    rdReg(8'h1C, 32'h0000_FF01, "eventSaturate");

    // Uptime coherence across a 32-bit carry
    @(posedge PicoClk);
    #1 force dut.count = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.count;
    rdReg(8'h14, 32'hFFFF_FFFF, "uptimeLo");
    rdReg(8'h18, 32'h0000_0001, "uptimeHi");

    // Reset on the edge right after a read
    wrReg(8'h20, 32'h0000_1234);
    fallDcm(1);
    rdReg(8'h20, 32'h0000_1234, "scratchPreRst");
    idle(LAT);
    rdReg(8'h04, CAPSV, "discardedRd");
    doReset();
    applyStimulus(1'b1, 1'b0, BASE + 32'h14, 32'd0, 32'd8, 1'b1, "uptimeAfterRst");
    rdReg(8'h18, 32'h0, "hiAfterRst");
    rdReg(8'h1C, 32'h0, "eventAfterRst");
    rdReg(8'h20, 32'h0, "scratchAfterRst");
    idle(LAT + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pico_card_info.md
# pico_card_info

Parametrised card-information and housekeeping register block on the system PicoBus, replacing the fixed 32-bit card-info block. It returns identity registers for the card: status/magic, capabilities, version, bus widths and model. It adds live housekeeping state: a coherent 64-bit uptime counter, a DCM-lock event log and host-writable scratch registers. It supports a configurable bus width, scratch-register count and read latency.

## Interface
- DATA_W, 32, PicoBus data width (32 or 128); reported as SysPBWidth.
- BASE_ADDR, 32'h0001_0000, byte address of offset 0x00.
- NUM_SCRATCH, 4, scratch registers, 1..8.
- READ_LATENCY, 1, PicoRd-to-PicoDataOut latency in cycles, 1 or 2.
- MODEL_NUM, 16'h0000, card model number.
- VERSION, 32'h0, packed {major, minor, release, counter}.
- SIGNATURE, 12'h000, bitfile signature.
- CAPS, 32'h0, image capability word.
- PicoClk  in  1  sole clock; all logic is on the rising edge.
- PicoRst  in  1  reset, synchronous to PicoClk, active-high.
- PicoAddr  in  32  byte address, sampled with PicoRd/PicoWr.
- PicoDataIn  in  DATA_W  write data; only bits [31:0] are used.
- PicoDataOut  out  DATA_W  registered read data; 0 when not returning a read.
- PicoRd  in  1  read strobe, one cycle per access.
- PicoWr  in  1  write strobe, one cycle per access.
- UserPBWidth  in  8  user PicoBus width, static.
- DcmLocked  in  1  asynchronous lock indicator, double-flopped internally.
- FlashStatus  in  1  asynchronous flash status, double-flopped internally.

## Operation
- Decode: hit when PicoAddr[31:8] == BASE_ADDR[31:8]; word = PicoAddr[7:2]. A miss or an unmapped offset reads 0. Writes to read-only or unmapped offsets are ignored.
- Register map (offset: content):
  - 0x00: {SIGNATURE, 2'b0, dcm_s, flash_s, PICO_MAGIC_NUM}
  - 0x04: CAPS
  - 0x08: VERSION
  - 0x0C: {16'h0, UserPBWidth, DATA_W[7:0]}
  - 0x10: {16'h0, MODEL_NUM}
  - 0x14: UPTIME_LO
  - 0x18: UPTIME_HI
  - 0x1C: EVENT
  - 0x20+4*i: SCRATCH[i]
- Read data occupies bits [31:0] of PicoDataOut; bits [DATA_W-1:32] are always 0.
- Uptime:
  - 64-bit counter, +1 every cycle, wraps 2^64-1 -> 0.
  - A UPTIME_LO read returns count[31:0] and, at the same edge, loads hi_snap <= count[63:32].
  - A UPTIME_HI read returns hi_snap, never the live count.
- EVENT register:
  - bit0 lock_lost: sticky, set on a 1->0 transition of the synchronised dcm_s.
  - bits[15:8] lost_cnt: 8-bit saturating count of those falls, stops at 8'hFF.
  - Write with bit0=1 clears lock_lost. Write with bit31=1 clears lost_cnt.
  - A fall coincident with a clear: set or increment wins (lock_lost=1, lost_cnt=1).
- SCRATCH: read/write, 32 bits each.
- Simultaneous PicoRd and PicoWr to the same offset: the read returns the pre-write value and the write takes effect.
- Reset values: PicoDataOut=0, count=0, hi_snap=0, EVENT=0, all SCRATCH=0, synchroniser flops=0, read pipeline cleared.

## Timing
- Every access is sampled at rising edge N where the strobe is high.
- READ_LATENCY=1: data is valid on PicoDataOut during cycle N+1. The output returns to 0 the following cycle unless another read is present.
- READ_LATENCY=2: one extra output register; data is valid in cycle N+2. Back-to-back reads every cycle are supported, with one result per cycle and in order.
- The UPTIME_LO value returned is count as held before edge N, i.e. the pre-increment value.
- A write takes effect at edge N and is visible to a read sampled at edge N+1.
- dcm_s and flash_s lag their pins by 2 cycles. A lock_lost caused by a pin fall is readable from a read sampled 3 edges after the fall.
- PicoRst asserted at any edge: all state returns to reset values at that edge, and in-flight read data is discarded (PicoDataOut=0 next cycle). Strobes during reset are ignored.

## Structure
- Shared package pico_card_info_pkg holds:
  - register offsets;
  - PICO_MAGIC_NUM;
  - EVENT field positions (lock_lost bit 0, lost_cnt [15:8], count-clear bit 31);
  - the allowed DATA_W and READ_LATENCY values, checked by elaboration-time assertions.
- Sub-module pico_bit_sync: 2-flop synchroniser with a reset value parameter. It is instantiated twice, once for DcmLocked and once for FlashStatus.
- Remaining logic in the top level: decode, uptime/snapshot, EVENT, scratch array, read mux, output pipeline.

## Test plan
- Identity readout: DATA_W=128, MODEL_NUM=16'h0E18, read 0x10 then 0x0C with UserPBWidth=8'd64 -> 32'h0000_0E18, then 32'h0000_4080. Bits [127:32] stay 0 and the output is 0 in idle cycles.
- Uptime coherence: force count to 64'h0000_0001_FFFF_FFFF (backdoor), read LO then HI -> 32'hFFFF_FFFF, then 32'h0000_0001, even though count has wrapped to 0x2_0000_0000+ by the HI read.
- Lock events: toggle DcmLocked 1->0 three times -> EVENT=32'h0000_0301. Write 32'h1 -> 32'h0000_0300. Write 32'h8000_0000 -> 0. 300 falls -> lost_cnt=8'hFF.
- Scratch: NUM_SCRATCH=4, write 32'hDEAD_BEEF to 0x2C with a simultaneous read of 0x2C -> that read returns 0, the next read returns 32'hDEAD_BEEF. Write to 0x30 (unmapped) reads back 0.
- Latency/pipeline: READ_LATENCY=2, reads of 0x00, 0x04 and 0x08 on consecutive cycles -> Status, CAPS and VERSION on cycles N+2, N+3 and N+4.
- Reset mid-operation: assert PicoRst on the edge after a read -> PicoDataOut=0, EVENT, SCRATCH and count all 0, and the first read of UPTIME_LO after release returns a small value (< 8).
